// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial stage with a single-entry holding buffer.
// Latency: a word accepted at edge N shows its first bit on ser_out after edge N+1.
// Backpressure: in_ready = !hold_valid; a full holding buffer stalls upstream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    upstream word offer; in_ready indicates hold buffer empty
//   ser_out/ser_valid   serial bit and its qualifier (ser_out is 0 when not valid)
//   frame_start/done    first / last bit of a word
//   busy                shifting in progress or a word waiting in the hold buffer
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             load;
  logic             ser_out_nxt, ser_valid_nxt, frame_start_nxt, frame_done_nxt, busy_nxt;

  assign in_ready = !hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_valid  <= 1'b0;
      hold_reg    <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_valid  <= hold_valid_nxt;
      hold_reg    <= hold_reg_nxt;
      shift_reg   <= shift_nxt;
      bit_cnt     <= cnt_nxt;
      ser_out     <= ser_out_nxt;
      ser_valid   <= ser_valid_nxt;
      frame_start <= frame_start_nxt;
      frame_done  <= frame_done_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_valid_nxt = hold_valid;
    hold_reg_nxt   = hold_reg;
    shift_nxt      = shift_reg;
    cnt_nxt        = bit_cnt;
    load           = 1'b0;

    // Accept only into an empty buffer, so it never coincides with a load.
    if (in_valid && in_ready) begin
      hold_valid_nxt = 1'b1;
      hold_reg_nxt   = in_data;
    end

    case (state)
      IDLE: begin
        if (hold_valid) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
          // Reload straight from the buffer on the last bit: no idle gap.
          if (hold_valid) load = 1'b1;
          else            state_nxt = IDLE;
        end else begin
          shift_nxt = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
          cnt_nxt   = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt      = SHIFT;
      shift_nxt      = hold_reg;
      cnt_nxt        = '0;
      hold_valid_nxt = 1'b0;
    end

    // Outputs are registered from next-state values, so they line up with
    // the bit that shift_reg holds after this edge.
    ser_valid_nxt   = (state_nxt == SHIFT);
    ser_out_nxt     = ser_valid_nxt & (LSB_FIRST ? shift_nxt[0] : shift_nxt[WIDTH-1]);
    frame_start_nxt = ser_valid_nxt & (cnt_nxt == '0);
    frame_done_nxt  = ser_valid_nxt & (cnt_nxt == LAST);
    busy_nxt        = (state_nxt == SHIFT) | hold_valid_nxt;
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: one LSB-first and one MSB-first instance share
// the same input stream; a word-level scoreboard rebuilds words from the serial
// outputs, plus a vector table and directed multi-cycle sequences.
module tb_byte_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_a, so_a, sv_a, fs_a, fd_a, bz_a;
  logic rdy_b, so_b, sv_b, fs_b, fd_b, bz_b;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .frame_start(fs_a), .frame_done(fd_a), .busy(bz_a));

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .ser_out(so_b), .ser_valid(sv_b), .frame_start(fs_b), .frame_done(fd_b), .busy(bz_b));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int c; logic b; logic fs; logic fd; } ev_t;
  typedef struct { int c; logic [7:0] d; } acc_t;
  typedef struct { logic [7:0] d; logic [7:0] tx_a; logic [7:0] tx_b; } vec_t;

  ev_t        elog[$];
  acc_t       alog[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         pos[2];
  logic [7:0] word[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: accepted words in order; each DUT must emit them intact.
  always @(posedge clk) begin
    if (rst_n && in_valid && rdy_a) begin
      qa.push_back(in_data);
      alog.push_back('{cyc, in_data});
    end
    if (rst_n && in_valid && rdy_b) qb.push_back(in_data);
  end

  task automatic mon(input int d, input logic sv, input logic so, input logic fs,
                     input logic fd, input logic bz, input logic rdy);
    int qs;
    qs = (d == 0) ? qa.size() : qb.size();
    // Pending words = in the hold buffer or being shifted.
    chk("busy", bz, qs != 0);
    chk("in_ready", rdy, (qs - int'(sv)) == 0);
    if (sv) begin
      chk("frame_start", fs, pos[d] == 0);
      chk("frame_done", fd, pos[d] == W - 1);
      if (d == 0) word[d][pos[d]] = so;
      else        word[d][W-1-pos[d]] = so;
      pos[d]++;
      if (pos[d] == W) begin
        pos[d] = 0;
        if (qs == 0)     chk("word_unexpected", 1, 0);
        else if (d == 0) chk("word_a", word[d], qa.pop_front());
        else             chk("word_b", word[d], qb.pop_front());
      end
    end else begin
      chk("idle_out", {so, fs, fd}, 0);
      chk("no_gap", pos[d], 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pos[0] = 0;
      pos[1] = 0;
      qa.delete();
      qb.delete();
    end else begin
      mon(0, sv_a, so_a, fs_a, fd_a, bz_a, rdy_a);
      mon(1, sv_b, so_b, fs_b, fd_b, bz_b, rdy_b);
      if (sv_a) elog.push_back('{cyc, so_a, fs_a, fd_a});
    end
  end

  task automatic send(input logic [7:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!rdy_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bz_a || sv_a || bz_b || sv_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [15:0] exp2;
    logic [23:0] exp3;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'h80, 8'h80, 8'h01};
    tbl[3] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[4] = '{8'h0F, 8'h0F, 8'hF0};
    tbl[5] = '{8'hC1, 8'hC1, 8'h83};

    // Reset state; offers during reset must be ignored.
    #1;
    chk("reset_out_a", {so_a, sv_a, fs_a, fd_a, bz_a}, 0);
    chk("reset_out_b", {so_b, sv_b, fs_b, fd_b, bz_b}, 0);
    chk("reset_ready", {rdy_a, rdy_b}, 2'b11);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset_quiet", {sv_a, bz_a, sv_b, bz_b, rdy_a}, 5'b00001);
    end

    // Single words from the table, checked bit by bit on both instances.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_idle", {sv_a, sv_b}, 0);
      chk("busy_pending", {bz_a, bz_b}, 2'b11);
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        chk("bit_a", {sv_a, so_a, fs_a, fd_a}, {1'b1, tbl[i].tx_a[k], k == 0, k == W - 1});
        chk("bit_b", {sv_b, so_b, fs_b, fd_b}, {1'b1, tbl[i].tx_b[k], k == 0, k == W - 1});
      end
      @(negedge clk);
      chk("done_idle", {sv_a, bz_a, sv_b, bz_b}, 0);
    end

    // Back-to-back: 16 contiguous bits, done on bit 8, start on bit 9.
    elog.delete();
    send(8'h01);
    send(8'h80);
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_len", elog.size(), 16);
    exp2 = 16'h8001;
    if (elog.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk("b2b_bit", elog[k].b, exp2[k]);
        chk("b2b_cyc", elog[k].c - elog[0].c, k);
        chk("b2b_frame", {elog[k].fs, elog[k].fd}, {k % 8 == 0, k % 8 == 7});
      end
    end

    // Back-pressure: third word held off until the second one loads.
    elog.delete();
    alog.delete();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    in_valid = 1'b0;
    wait_idle();
    chk("bp_accepts", alog.size(), 3);
    if (alog.size() == 3) begin
      chk("bp_gap12", alog[1].c - alog[0].c, 2);
      chk("bp_gap23", alog[2].c - alog[1].c, 8);
      chk("bp_order", {alog[0].d, alog[1].d, alog[2].d}, 24'h112233);
    end
    chk("bp_len", elog.size(), 24);
    exp3 = 24'h332211;
    if (elog.size() == 24) begin
      for (int k = 0; k < 24; k++) begin
        chk("bp_bit", elog[k].b, exp3[k]);
        chk("bp_cyc", elog[k].c - elog[0].c, k);
      end
    end

    // Reset during bit 3 of 8'hFF with 8'h0F queued.
    send(8'hFF);
    send(8'h0F);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_shifting", {sv_a, so_a, bz_a}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", {so_a, sv_a, fs_a, fd_a, bz_a}, 0);
    chk("async_reset_b", {so_b, sv_b, fs_b, fd_b, bz_b}, 0);
    chk("async_reset_ready", {rdy_a, rdy_b}, 2'b11);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    elog.delete();
    repeat (20) begin
      @(negedge clk);
      chk("post_reset_quiet", {sv_a, sv_b, bz_a, bz_b}, 0);
    end
    send(8'h3C);
    in_valid = 1'b0;
    wait_idle();
    chk("post_reset_len", elog.size(), 8);

    // Random words with random gaps.
    alog.delete();
    for (int i = 0; i < 500; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) gap += $urandom_range(5, 15);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
      send(8'($urandom));
    end
    in_valid = 1'b0;
    wait_idle();
    chk("rand_accepts", alog.size(), 500);
    chk("rand_drained", qa.size() + qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
